// File: rtl/tdm_pkg.sv
// Shared mode encodings and the idle-word helper for the TDM transmission block.
package tdm_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
   localparam int   IDLE_MAX_W  = 64;

   // Idle lines sit at all-ones; callers keep the low `width` bits.
   function automatic logic [IDLE_MAX_W-1:0] idle_value(input int width);
      logic [IDLE_MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < IDLE_MAX_W; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/tdm_scan_ctrl.sv
// Slot selection: manual load or round-robin scan with a programmable dwell,
// plus the frame flag marking the first cycle of slot 0.
module tdm_scan_ctrl
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int DWELL    = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel_manual,
   output logic [SEL_W-1:0] sel_q,
   output logic             frm
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(CHANNELS - 1);

   logic [DW_W-1:0]  dwell_q;
   logic [DW_W-1:0]  dwell_nxt;
   logic [SEL_W-1:0] sel_nxt;

   // Manual mode overrides any pending dwell wrap; the >= also folds an
   // out-of-range manual slot back to 0 once scanning resumes.
   always_comb begin
      sel_nxt   = sel_q;
      dwell_nxt = dwell_q;
      if (mode == MODE_MANUAL) begin
         sel_nxt   = sel_manual;
         dwell_nxt = '0;
      end else if (en) begin
         if (dwell_q == DWELL_LAST) begin
            dwell_nxt = '0;
            sel_nxt   = (sel_q >= LAST_SLOT) ? '0 : sel_q + 1'b1;
         end else begin
            dwell_nxt = dwell_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         dwell_q <= '0;
      end else begin
         sel_q   <= sel_nxt;
         dwell_q <= dwell_nxt;
      end
   end

   assign frm = (mode == MODE_SCAN) && en && (sel_q == '0) && (dwell_q == '0);

endmodule

// File: rtl/tdm_transmission.sv
// Registered TDM mux/demux: one selected channel crosses the link register
// and lands on its matching output; every other output idles at all-ones.
module tdm_transmission
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 1,
   parameter int DWELL    = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      iClk,
   input  logic                      iRst_n,
   input  logic                      iEn,
   input  logic                      iMode,
   input  logic [SEL_W-1:0]          iSel,
   input  logic [CHANNELS*WIDTH-1:0] iData,
   output logic [CHANNELS*WIDTH-1:0] oData,
   output logic [SEL_W-1:0]          oSel,
   output logic                      oValid,
   output logic                      oFrame
);

   localparam logic [WIDTH-1:0] IDLE = WIDTH'(idle_value(WIDTH));

   logic [SEL_W-1:0]          sel_q;
   logic                      frm;
   logic [WIDTH-1:0]          picked;
   logic                      in_range;
   logic [WIDTH-1:0]          link_p1;
   logic [SEL_W-1:0]          sel_p1;
   logic                      vld_p1;
   logic                      frm_p1;
   logic [CHANNELS*WIDTH-1:0] demux;

   tdm_scan_ctrl #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL),
      .SEL_W    (SEL_W)
   ) u_scan_ctrl (
      .clk        (iClk),
      .rst_n      (iRst_n),
      .en         (iEn),
      .mode       (iMode),
      .sel_manual (iSel),
      .sel_q      (sel_q),
      .frm        (frm)
   );

   always_comb begin
      picked = IDLE;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel_q == SEL_W'(k)) picked = iData[k*WIDTH +: WIDTH];
      end
   end

   assign in_range = int'(sel_q) < CHANNELS;

   // Stage 1: sample the selected channel onto the link
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         link_p1 <= IDLE;
         sel_p1  <= '0;
         vld_p1  <= 1'b0;
         frm_p1  <= 1'b0;
      end else begin
         link_p1 <= picked;
         sel_p1  <= sel_q;
         vld_p1  <= iEn && in_range;
         frm_p1  <= frm;
      end
   end

   always_comb begin
      demux = {CHANNELS{IDLE}};
      for (int k = 0; k < CHANNELS; k++) begin
         if (vld_p1 && (sel_p1 == SEL_W'(k))) demux[k*WIDTH +: WIDTH] = link_p1;
      end
   end

   // Stage 2: demultiplexed outputs
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oData  <= {CHANNELS{IDLE}};
         oSel   <= '0;
         oValid <= 1'b0;
         oFrame <= 1'b0;
      end else begin
         oData  <= demux;
         oSel   <= sel_p1;
         oValid <= vld_p1;
         oFrame <= frm_p1;
      end
   end

endmodule

// File: tb/tb_tdm_transmission.sv
// Scoreboard bench for tdm_transmission: stimulus queues expected live slots,
// a negedge monitor pops and compares them whenever oValid is high.
module tb_tdm_transmission;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic       mode  = 1'b0;
   logic [2:0] sel   = 3'd0;
   logic [7:0] data  = 8'h00;
   logic [7:0] odata;
   logic [2:0] osel;
   logic       ovalid;
   logic       oframe;

   logic       en6   = 1'b0;
   logic       mode6 = 1'b0;
   logic [2:0] sel6  = 3'd0;
   logic [5:0] data6 = 6'h00;
   logic [5:0] odata6;
   logic [2:0] osel6;
   logic       ovalid6;
   logic       oframe6;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] sel;
      logic       frm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   sc_slot = 0;
   int   sc_dwell = 0;

   always #5 clk = ~clk;

   tdm_transmission #(.CHANNELS(8), .WIDTH(1), .DWELL(4)) dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .iEn    (en),
      .iMode  (mode),
      .iSel   (sel),
      .iData  (data),
      .oData  (odata),
      .oSel   (osel),
      .oValid (ovalid),
      .oFrame (oframe)
   );

   tdm_transmission #(.CHANNELS(6), .WIDTH(1), .DWELL(4)) dut6 (
      .iClk   (clk),
      .iRst_n (rst_n),
      .iEn    (en6),
      .iMode  (mode6),
      .iSel   (sel6),
      .iData  (data6),
      .oData  (odata6),
      .oSel   (osel6),
      .oValid (ovalid6),
      .oFrame (oframe6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] low_bit(input int slot);
      logic [7:0] v;
      v = 8'hFF;
      v[slot] = 1'b0;
      return v;
   endfunction

   task automatic expect_slot(input int slot, input logic [7:0] d, input logic f);
      exp_t e;
      e.data = d;
      e.sel  = 3'(slot);
      e.frm  = f;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // One enabled scan interval per step; all channel inputs are 0 here.
   task automatic scan_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         mode = 1'b1;
         en   = 1'b1;
         expect_slot(sc_slot, low_bit(sc_slot), (sc_slot == 0) && (sc_dwell == 0));
         if (sc_dwell == 3) begin
            sc_dwell = 0;
            sc_slot  = (sc_slot + 1) % 8;
         end else begin
            sc_dwell++;
         end
         tick();
      end
   endtask

   always @(negedge clk) begin
      checks++;
      if (ovalid) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got sel %0d data %0h, required no live slot", osel, odata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({odata, osel, oframe} !== {mon_e.data, mon_e.sel, mon_e.frm}) begin
               errors++;
               $display("FAIL slot_out: got data %0h sel %0d frame %0b, required data %0h sel %0d frame %0b",
                        odata, osel, oframe, mon_e.data, mon_e.sel, mon_e.frm);
            end
         end
      end else if (odata !== 8'hFF || oframe !== 1'b0) begin
         errors++;
         $display("FAIL idle_out: got data %0h frame %0b, required data ff frame 0", odata, oframe);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, required completion");
      $fatal(1);
   end

   initial begin
      // Reset state, asserted asynchronously before any clock edge
      mode = 1'b0; en = 1'b0; sel = 3'd3; data = 8'h55;
      #1 rst_n = 1'b0;
      #1;
      check("reset_data", odata, 8'hFF);
      check("reset_sel", osel, 3'd0);
      check("reset_valid", ovalid, 1'b0);
      check("reset_frame", oframe, 1'b0);
      check("reset_data6", odata6, 6'h3F);
      tick();
      tick();
      #3 rst_n = 1'b1;
      tick();
      tick();

      // Manual hold on slot 3 (iData bit 3 = 0), then slot 2 (bit 2 = 1)
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_slot(3, 8'hF7, 1'b0);
         tick();
      end
      sel = 3'd2;
      expect_slot(3, 8'hF7, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         expect_slot(2, 8'hFF, 1'b0);
         tick();
      end
      en = 1'b0; sel = 3'd0;
      tick();
      tick();
      tick();
      check("manual_drained_valid", ovalid, 1'b0);

      // Scan sweep: slot 0..7, four cycles each, frame on slot 0 entry
      data = 8'h00; mode = 1'b1;
      tick();
      scan_cycles(36);

      // Enable toggle during slot 5, dwell 2
      for (int g = 0; g < 64 && !(sc_slot == 5 && sc_dwell == 2); g++) scan_cycles(1);
      en = 1'b0;
      tick();
      tick();
      check("en_low_data", odata, 8'hFF);
      check("en_low_valid", ovalid, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      scan_cycles(6);

      // Scan -> manual during slot 4, then back to scan from slot 1
      for (int g = 0; g < 64 && !(sc_slot == 4 && sc_dwell == 2); g++) scan_cycles(1);
      mode = 1'b0; sel = 3'd1; en = 1'b1;
      expect_slot(4, low_bit(4), 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_slot(1, low_bit(1), 1'b0);
         tick();
      end
      sc_slot = 1; sc_dwell = 0;
      scan_cycles(10);

      // Async reset mid-frame; the in-flight slot from the previous interval is lost
      @(negedge clk);
      #2 rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      check("midreset_data", odata, 8'hFF);
      check("midreset_sel", osel, 3'd0);
      check("midreset_valid", ovalid, 1'b0);
      check("midreset_frame", oframe, 1'b0);
      tick();
      tick();
      #3 rst_n = 1'b1;
      sc_slot = 0; sc_dwell = 0;
      scan_cycles(9);
      en = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("scoreboard_empty", exp_q.size(), 0);

      // Out-of-range manual select on the 6-channel instance
      mode6 = 1'b0; en6 = 1'b1; sel6 = 3'd7; data6 = 6'h00;
      for (int i = 0; i < 4; i++) tick();
      check("oor7_data", odata6, 6'h3F);
      check("oor7_valid", ovalid6, 1'b0);
      sel6 = 3'd5;
      tick();
      tick();
      tick();
      check("ch6_slot5_data", odata6, 6'h1F);
      check("ch6_slot5_valid", ovalid6, 1'b1);
      check("ch6_slot5_sel", osel6, 3'd5);
      sel6 = 3'd6;
      tick();
      tick();
      tick();
      check("oor6_data", odata6, 6'h3F);
      check("oor6_valid", ovalid6, 1'b0);
      check("oor6_frame", oframe6, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
